// File: rtl/pwm_multichannel_gen_pkg.sv
// Shared types for the multichannel PWM generator: alignment mode and
// counter direction encodings.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/pwm_multichannel_gen_channel.sv
// One PWM channel: duty shadow register, active duty loaded at reload,
// unsigned compare against the shared counter and a registered output.
module pwm_channel #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_duty,
  input  logic             reload,
  input  logic [WIDTH-1:0] cnt,
  output logic             pwm
);

  logic [WIDTH-1:0] duty_sh_r;
  logic [WIDTH-1:0] duty_act_r;
  logic             pwm_r;

  // Host writes land in the shadow; they never touch the running duty directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_sh_r <= {WIDTH{1'b0}};
    end else if (wr_en) begin
      duty_sh_r <= wr_duty;
    end else begin
      duty_sh_r <= duty_sh_r;
    end
  end

  // Active duty follows the shadow while idle and only at boundaries while running,
  // so a same-clock write is picked up one period later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_act_r <= {WIDTH{1'b0}};
      pwm_r      <= 1'b0;
    end else begin
      if (!enable || reload) begin
        duty_act_r <= duty_sh_r;
      end else begin
        duty_act_r <= duty_act_r;
      end
      pwm_r <= enable && (cnt < duty_act_r);
    end
  end

  assign pwm = pwm_r;

endmodule

// File: rtl/pwm_multichannel_gen.sv
// CH-channel PWM generator: shared prescaler and edge/center-aligned period
// counter, with period/mode/duty values reloaded glitch-free at period boundaries.
module pwm_multichannel_gen
  import pwm_pkg::*;
#(
  parameter  int CH    = 4,
  parameter  int WIDTH = 8,
  parameter  int PSC_W = 8,
  localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             mode_in,
  input  logic [PSC_W-1:0] psc_in,
  input  logic [WIDTH-1:0] period_in,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [WIDTH-1:0] wr_duty,
  output logic [CH-1:0]    pwm_out,
  output logic             period_tick
);

  logic [PSC_W-1:0] psc_cnt_r, psc_nxt_s;
  logic [WIDTH-1:0] cnt_r, cnt_nxt_s;
  logic             dir_r, dir_nxt_s;
  logic [WIDTH-1:0] period_act_r;
  pwm_mode_t        mode_act_r;
  logic             period_tick_r;
  logic             tick_s;
  logic             boundary_s;
  logic [CH-1:0]    wr_sel_s;

  // Tick and period-boundary detection for the active alignment mode.
  always_comb begin
    tick_s     = enable && (psc_cnt_r == psc_in);
    boundary_s = 1'b0;
    case (mode_act_r)
      PWM_EDGE:   boundary_s = tick_s && (cnt_r >= period_act_r);
      // a zero period in center mode never leaves 0, so every tick is a boundary
      PWM_CENTER: boundary_s = tick_s && (cnt_r == {WIDTH{1'b0}}) &&
                               ((dir_r == DIR_DOWN) || (period_act_r == {WIDTH{1'b0}}));
      default:    boundary_s = 1'b0;
    endcase
  end

  // Next prescaler, counter and direction values.
  always_comb begin
    psc_nxt_s = (psc_cnt_r >= psc_in) ? {PSC_W{1'b0}} : psc_cnt_r + 1'b1;
    cnt_nxt_s = cnt_r;
    dir_nxt_s = dir_r;
    if (!enable) begin
      psc_nxt_s = {PSC_W{1'b0}};
      cnt_nxt_s = {WIDTH{1'b0}};
      dir_nxt_s = DIR_UP;
    end else if (boundary_s) begin
      // center mode is already sitting at 0, so the new period starts climbing at once
      dir_nxt_s = DIR_UP;
      if ((mode_act_r == PWM_CENTER) && (period_in != {WIDTH{1'b0}})) begin
        cnt_nxt_s = {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
        cnt_nxt_s = {WIDTH{1'b0}};
      end
    end else if (!tick_s) begin
      cnt_nxt_s = cnt_r;
    end else if (mode_act_r == PWM_EDGE) begin
      cnt_nxt_s = cnt_r + 1'b1;
    end else if (dir_r == DIR_UP) begin
      if (cnt_r >= period_act_r) begin
        cnt_nxt_s = cnt_r - 1'b1;
        dir_nxt_s = DIR_DOWN;
      end else begin
        cnt_nxt_s = cnt_r + 1'b1;
      end
    end else begin
      cnt_nxt_s = cnt_r - 1'b1;
    end
  end

  // Shared counter state plus period/mode shadows that track inputs while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc_cnt_r     <= {PSC_W{1'b0}};
      cnt_r         <= {WIDTH{1'b0}};
      dir_r         <= DIR_UP;
      period_act_r  <= {WIDTH{1'b0}};
      mode_act_r    <= PWM_EDGE;
      period_tick_r <= 1'b0;
    end else begin
      psc_cnt_r     <= psc_nxt_s;
      cnt_r         <= cnt_nxt_s;
      dir_r         <= dir_nxt_s;
      period_tick_r <= boundary_s;
      if (!enable || boundary_s) begin
        period_act_r <= period_in;
        mode_act_r   <= pwm_mode_t'(mode_in);
      end else begin
        period_act_r <= period_act_r;
        mode_act_r   <= mode_act_r;
      end
    end
  end

  // Channel select decode; an out-of-range wr_ch matches no channel.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      wr_sel_s[i] = wr_en && (wr_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    pwm_channel #(.WIDTH(WIDTH)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .wr_en   (wr_sel_s[g]),
      .wr_duty (wr_duty),
      .reload  (boundary_s),
      .cnt     (cnt_r),
      .pwm     (pwm_out[g])
    );
  end

  assign period_tick = period_tick_r;

endmodule
